fwd_operand_stage: RTL and testbench
====================================

Name: fwd_operand_stage

Overview:
- Parametrised operand-forwarding stage for the pipelined CPU.
- Supersedes the fixed 3-input 32-bit operand mux.
- Resolves RAW hazards for NUM_OPS source operands internally by comparing source register addresses against the EX/MEM and MEM/WB destinations, instead of taking an external select.
- Registers the selected operands into an ID/EX-style output register with stall, flush, valid tracking and write-back snooping while stalled.

Parameters:
- DATA_W, 32, operand/result width in bits
- ADDR_W, 5, register-file address width
- NUM_OPS, 2, number of source operands handled in parallel

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-low
- stall_i  input  1  hold output register contents (hazard stall)
- flush_i  input  1  invalidate output register (branch/exception)
- in_valid_i  input  1  incoming instruction valid
- rs_addr_i  input  NUM_OPS*ADDR_W  source register addresses; operand k occupies bits [k*ADDR_W +: ADDR_W]
- rf_data_i  input  NUM_OPS*DATA_W  register-file read data, same packing
- exmem_wr_i  input  1  EX/MEM instruction writes a register
- exmem_rd_i  input  ADDR_W  EX/MEM destination register
- exmem_data_i  input  DATA_W  EX/MEM ALU result
- memwb_wr_i  input  1  MEM/WB instruction writes a register
- memwb_rd_i  input  ADDR_W  MEM/WB destination register
- memwb_data_i  input  DATA_W  MEM/WB write-back data
- out_valid_o  output  1  registered operands valid
- op_data_o  output  NUM_OPS*DATA_W  registered forwarded operands
- op_addr_o  output  NUM_OPS*ADDR_W  registered source addresses
- op_sel_o  output  NUM_OPS*2  registered source code per operand (debug/perf)

Behaviour:
- Reset: rst_i low asynchronously clears out_valid_o, op_data_o, op_addr_o and op_sel_o to 0. Registers load on the first rising edge after release.
- Per-operand select (combinational), evaluated in priority order:
  - rs==0: SEL_RF, value = rf_data. Register 0 is never forwarded.
  - exmem_wr_i && exmem_rd_i==rs: SEL_EXMEM, value = exmem_data_i.
  - memwb_wr_i && memwb_rd_i==rs: SEL_MEMWB, value = memwb_data_i.
  - otherwise: SEL_RF, value = rf_data.
- Codes: SEL_RF=2'b00, SEL_MEMWB=2'b01, SEL_EXMEM=2'b10. 2'b11 is reserved and never produced.
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Per-edge priority: flush > stall > load.
  - flush_i=1: out_valid_o<=0; op_data_o, op_addr_o and op_sel_o <=0. Overrides a simultaneous stall_i.
  - stall_i=1 (no flush): out_valid_o, op_addr_o and op_sel_o hold.
    - Write-back snoop: for each held operand k with op_addr_o[k]!=0, memwb_wr_i=1 and memwb_rd_i==op_addr_o[k], op_data_o[k]<=memwb_data_i. op_sel_o[k]<=SEL_MEMWB.
    - EX/MEM is not snooped during stall.
  - Otherwise (load): out_valid_o<=in_valid_i; op_addr_o<=rs_addr_i; op_data_o and op_sel_o <= combinational select result.
  - in_valid_i=0 still loads data and addresses; only out_valid_o is 0.
- Snoop applies even if out_valid_o=0.
- Both operands may match the same producer. Each operand resolves independently.
- All comparisons are full ADDR_W equality. Data is never truncated or extended.
- No combinational path from any input to any output.

Decomposition:
- Shared package fwd_pkg:
  - SEL_W=2
  - localparams SEL_RF, SEL_MEMWB, SEL_EXMEM
  - REG_ZERO={ADDR_W{1'b0}} convention
- One natural sub-module: fwd_select (combinational, single operand). Inputs: rs, rf_data, both producer ports. Outputs: value and sel code.
- fwd_operand_stage instantiates NUM_OPS copies via generate and owns all sequential logic.

Test Plan:
- Reset mid-operation: load op0=0xDEADBEEF with valid, assert rst_i low between edges -> all outputs 0 immediately (before next edge), stay 0 while low.
- Double hazard priority: rs0=5, exmem rd=5 data=0x11, memwb rd=5 data=0x22, rf=0x33 -> next edge op0=0x11, sel=2'b10. Drop exmem_wr_i -> op0=0x22, sel=2'b01. Drop memwb_wr_i -> op0=0x33, sel=2'b00.
- Zero register: rs0=0, exmem rd=0 wr=1 data=0xFFFF -> op0=rf_data (0), sel=2'b00.
- Stall snoop: load rs1=7 rf=0x100 (sel 00), then stall_i=1 with memwb wr=1 rd=7 data=0x200 -> op1=0x200, sel=2'b01, op_addr and out_valid unchanged. Same with rd=8 -> op1 unchanged.
- Flush vs stall: stall_i=1 and flush_i=1 on the same edge with out_valid_o=1 -> out_valid_o=0, op_data_o=0.
- NUM_OPS=3, DATA_W=64 build: independent hazards on each operand (rs=1/2/3 matching exmem/memwb/none) -> sel codes 10/01/00, correct 64-bit values in each lane.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared definitions for the operand-forwarding stage: select-code width and
// the source encodings reported per operand.
package fwd_pkg;

    localparam int unsigned SEL_W = 2;

    // 2'b11 is reserved and never produced by the select logic.
    typedef enum logic [SEL_W-1:0] {
        SEL_RF    = 2'b00,
        SEL_MEMWB = 2'b01,
        SEL_EXMEM = 2'b10
    } sel_e;

endpackage

// File: rtl/fwd_select.sv
// Single-operand RAW hazard resolver: picks EX/MEM, MEM/WB or register-file
// data for one source register, youngest producer first.
module fwd_select
    import fwd_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] rs_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              exmem_wr_i,
    input  logic [ADDR_W-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_data_i,
    input  logic              memwb_wr_i,
    input  logic [ADDR_W-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output logic [DATA_W-1:0] value_o,
    output sel_e              sel_o
);

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    always_comb begin
        value_o = rf_data_i;
        sel_o   = SEL_RF;
        // Register 0 is hardwired, so a producer targeting it must never win.
        if (rs_i == REG_ZERO) begin
            value_o = rf_data_i;
            sel_o   = SEL_RF;
        end else if (exmem_wr_i && (exmem_rd_i == rs_i)) begin
            value_o = exmem_data_i;
            sel_o   = SEL_EXMEM;
        end else if (memwb_wr_i && (memwb_rd_i == rs_i)) begin
            value_o = memwb_data_i;
            sel_o   = SEL_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_operand_stage.sv
// Parametrised operand-forwarding stage: resolves RAW hazards per operand and
// registers the results into an ID/EX register with stall, flush and WB snoop.
module fwd_operand_stage
    import fwd_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_OPS = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        stall_i,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    input  logic [NUM_OPS*ADDR_W-1:0]   rs_addr_i,
    input  logic [NUM_OPS*DATA_W-1:0]   rf_data_i,
    input  logic                        exmem_wr_i,
    input  logic [ADDR_W-1:0]           exmem_rd_i,
    input  logic [DATA_W-1:0]           exmem_data_i,
    input  logic                        memwb_wr_i,
    input  logic [ADDR_W-1:0]           memwb_rd_i,
    input  logic [DATA_W-1:0]           memwb_data_i,
    output logic                        out_valid_o,
    output logic [NUM_OPS*DATA_W-1:0]   op_data_o,
    output logic [NUM_OPS*ADDR_W-1:0]   op_addr_o,
    output logic [NUM_OPS*SEL_W-1:0]    op_sel_o
);

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    logic [DATA_W-1:0] fwd_val [NUM_OPS];
    sel_e              fwd_sel [NUM_OPS];

    logic                      valid_d, valid_q;
    logic [NUM_OPS*DATA_W-1:0] data_d,  data_q;
    logic [NUM_OPS*ADDR_W-1:0] addr_d,  addr_q;
    logic [NUM_OPS*SEL_W-1:0]  sel_d,   sel_q;

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        fwd_select #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_sel (
            .rs_i         (rs_addr_i[g*ADDR_W +: ADDR_W]),
            .rf_data_i    (rf_data_i[g*DATA_W +: DATA_W]),
            .exmem_wr_i   (exmem_wr_i),
            .exmem_rd_i   (exmem_rd_i),
            .exmem_data_i (exmem_data_i),
            .memwb_wr_i   (memwb_wr_i),
            .memwb_rd_i   (memwb_rd_i),
            .memwb_data_i (memwb_data_i),
            .value_o      (fwd_val[g]),
            .sel_o        (fwd_sel[g])
        );
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        if (flush_i) begin
            valid_d = 1'b0;
            data_d  = '0;
            addr_d  = '0;
            sel_d   = '0;
        end else if (stall_i) begin
            // Held operands pick up a retiring write so the stall cannot leave stale data.
            for (int unsigned k = 0; k < NUM_OPS; k++) begin
                if ((addr_q[k*ADDR_W +: ADDR_W] != REG_ZERO) && memwb_wr_i &&
                    (memwb_rd_i == addr_q[k*ADDR_W +: ADDR_W])) begin
                    data_d[k*DATA_W +: DATA_W] = memwb_data_i;
                    sel_d[k*SEL_W +: SEL_W]    = SEL_MEMWB;
                end
            end
        end else begin
            valid_d = in_valid_i;
            addr_d  = rs_addr_i;
            for (int unsigned k = 0; k < NUM_OPS; k++) begin
                data_d[k*DATA_W +: DATA_W] = fwd_val[k];
                sel_d[k*SEL_W +: SEL_W]    = fwd_sel[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            sel_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid_o = valid_q;
    assign op_data_o   = data_q;
    assign op_addr_o   = addr_q;
    assign op_sel_o    = sel_q;

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Self-checking bench for fwd_operand_stage: directed vector table, reset and
// wide-build sequences, then randomized traffic against a behavioural model.
module tb_fwd_operand_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Default build: DATA_W=32, ADDR_W=5, NUM_OPS=2
    logic        stall, flush, vld;
    logic [9:0]  rs_addr;
    logic [63:0] rf_data;
    logic        xw, ww;
    logic [4:0]  xr, wbrd;
    logic [31:0] xd, wd;
    logic        ov;
    logic [63:0] od;
    logic [9:0]  oa;
    logic [3:0]  os;

    // Wide build: DATA_W=64, ADDR_W=5, NUM_OPS=3
    logic         w_stall, w_flush, w_vld;
    logic [14:0]  w_rs;
    logic [191:0] w_rf;
    logic         w_xw, w_ww;
    logic [4:0]   w_xr, w_wr;
    logic [63:0]  w_xd, w_wd;
    logic         w_ov;
    logic [191:0] w_od;
    logic [14:0]  w_oa;
    logic [5:0]   w_os;

    fwd_operand_stage dut (
        .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush), .in_valid_i(vld),
        .rs_addr_i(rs_addr), .rf_data_i(rf_data),
        .exmem_wr_i(xw), .exmem_rd_i(xr), .exmem_data_i(xd),
        .memwb_wr_i(ww), .memwb_rd_i(wbrd), .memwb_data_i(wd),
        .out_valid_o(ov), .op_data_o(od), .op_addr_o(oa), .op_sel_o(os)
    );

    fwd_operand_stage #(.DATA_W(64), .ADDR_W(5), .NUM_OPS(3)) dut3 (
        .clk_i(clk), .rst_i(rst_n), .stall_i(w_stall), .flush_i(w_flush), .in_valid_i(w_vld),
        .rs_addr_i(w_rs), .rf_data_i(w_rf),
        .exmem_wr_i(w_xw), .exmem_rd_i(w_xr), .exmem_data_i(w_xd),
        .memwb_wr_i(w_ww), .memwb_rd_i(w_wr), .memwb_data_i(w_wd),
        .out_valid_o(w_ov), .op_data_o(w_od), .op_addr_o(w_oa), .op_sel_o(w_os)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".valid"}, 192'(ov), 192'(0));
        chk({name, ".data"},  192'(od), 192'(0));
        chk({name, ".addr"},  192'(oa), 192'(0));
        chk({name, ".sel"},   192'(os), 192'(0));
        chk({name, ".w_valid"}, 192'(w_ov), 192'(0));
        chk({name, ".w_data"},  w_od, 192'(0));
        chk({name, ".w_sel"},   192'(w_os), 192'(0));
    endtask

    typedef struct {
        logic st, fl, vl;
        logic [4:0]  rs0, rs1;
        logic [31:0] rf0, rf1;
        logic        xw; logic [4:0] xr; logic [31:0] xd;
        logic        ww; logic [4:0] wr; logic [31:0] wd;
        logic        ev;
        logic [31:0] ed0, ed1;
        logic [4:0]  ea0, ea1;
        logic [1:0]  es0, es1;
    } vec_t;

    vec_t vecs [12];

    // Behavioural reference: one record per operand, updated from the rules.
    logic        m_valid;
    logic [31:0] m_data [2];
    logic [4:0]  m_addr [2];
    logic [1:0]  m_sel  [2];

    function automatic void resolve(input logic [4:0] rs, input logic [31:0] rf,
                                    output logic [31:0] v, output logic [1:0] s);
        if (rs == 5'd0) begin v = rf; s = 2'b00; end
        else if (xw && xr == rs) begin v = xd; s = 2'b10; end
        else if (ww && wbrd == rs) begin v = wd; s = 2'b01; end
        else begin v = rf; s = 2'b00; end
    endfunction

    task automatic model_edge();
        logic [31:0] v;
        logic [1:0]  s;
        if (flush) begin
            m_valid = 1'b0;
            for (int k = 0; k < 2; k++) begin m_data[k] = '0; m_addr[k] = '0; m_sel[k] = '0; end
        end else if (stall) begin
            for (int k = 0; k < 2; k++)
                if (m_addr[k] != 5'd0 && ww && wbrd == m_addr[k]) begin
                    m_data[k] = wd; m_sel[k] = 2'b01;
                end
        end else begin
            m_valid = vld;
            for (int k = 0; k < 2; k++) begin
                resolve(rs_addr[k*5 +: 5], rf_data[k*32 +: 32], v, s);
                m_data[k] = v; m_sel[k] = s; m_addr[k] = rs_addr[k*5 +: 5];
            end
        end
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; vld = 0; rs_addr = '0; rf_data = '0;
        xw = 0; xr = '0; xd = '0; ww = 0; wbrd = '0; wd = '0;
        w_stall = 0; w_flush = 0; w_vld = 0; w_rs = '0; w_rf = '0;
        w_xw = 0; w_xr = '0; w_xd = '0; w_ww = 0; w_wr = '0; w_wd = '0;
    endtask

    initial begin
        vecs[0]  = '{1'b0,1'b0,1'b1, 5'd5,5'd7, 32'h33,32'h100, 1'b1,5'd5,32'h11, 1'b1,5'd5,32'h22, 1'b1, 32'h11,32'h100, 5'd5,5'd7, 2'd2,2'd0};
        vecs[1]  = '{1'b0,1'b0,1'b1, 5'd5,5'd7, 32'h33,32'h100, 1'b0,5'd5,32'h11, 1'b1,5'd5,32'h22, 1'b1, 32'h22,32'h100, 5'd5,5'd7, 2'd1,2'd0};
        vecs[2]  = '{1'b0,1'b0,1'b1, 5'd5,5'd7, 32'h33,32'h100, 1'b0,5'd5,32'h11, 1'b0,5'd5,32'h22, 1'b1, 32'h33,32'h100, 5'd5,5'd7, 2'd0,2'd0};
        vecs[3]  = '{1'b0,1'b0,1'b1, 5'd0,5'd7, 32'h0,32'h100, 1'b1,5'd0,32'hFFFF, 1'b0,5'd0,32'h0, 1'b1, 32'h0,32'h100, 5'd0,5'd7, 2'd0,2'd0};
        vecs[4]  = '{1'b1,1'b0,1'b1, 5'd3,5'd4, 32'hAAAA,32'hBBBB, 1'b1,5'd7,32'h999, 1'b1,5'd7,32'h200, 1'b1, 32'h0,32'h200, 5'd0,5'd7, 2'd0,2'd1};
        vecs[5]  = '{1'b1,1'b0,1'b1, 5'd3,5'd4, 32'hAAAA,32'hBBBB, 1'b0,5'd0,32'h0, 1'b1,5'd8,32'h300, 1'b1, 32'h0,32'h200, 5'd0,5'd7, 2'd0,2'd1};
        vecs[6]  = '{1'b1,1'b0,1'b1, 5'd3,5'd4, 32'hAAAA,32'hBBBB, 1'b0,5'd0,32'h0, 1'b1,5'd0,32'h444, 1'b1, 32'h0,32'h200, 5'd0,5'd7, 2'd0,2'd1};
        vecs[7]  = '{1'b1,1'b1,1'b1, 5'd3,5'd4, 32'hAAAA,32'hBBBB, 1'b1,5'd3,32'h5, 1'b1,5'd4,32'h6, 1'b0, 32'h0,32'h0, 5'd0,5'd0, 2'd0,2'd0};
        vecs[8]  = '{1'b0,1'b0,1'b0, 5'd9,5'd10, 32'hA,32'hB, 1'b1,5'd10,32'hE, 1'b1,5'd9,32'hF, 1'b0, 32'hF,32'hE, 5'd9,5'd10, 2'd1,2'd2};
        vecs[9]  = '{1'b1,1'b0,1'b1, 5'd1,5'd2, 32'h1,32'h2, 1'b0,5'd0,32'h0, 1'b1,5'd10,32'h55, 1'b0, 32'hF,32'h55, 5'd9,5'd10, 2'd1,2'd1};
        vecs[10] = '{1'b0,1'b0,1'b1, 5'd12,5'd12, 32'h1,32'h2, 1'b1,5'd12,32'hCAFE, 1'b0,5'd0,32'h0, 1'b1, 32'hCAFE,32'hCAFE, 5'd12,5'd12, 2'd2,2'd2};
        vecs[11] = '{1'b0,1'b0,1'b1, 5'd31,5'd31, 32'h1,32'h2, 1'b1,5'd15,32'hBAD, 1'b1,5'd31,32'h77, 1'b1, 32'h77,32'h77, 5'd31,5'd31, 2'd1,2'd1};

        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table on the default build
        for (int i = 0; i < 12; i++) begin
            stall = vecs[i].st; flush = vecs[i].fl; vld = vecs[i].vl;
            rs_addr = {vecs[i].rs1, vecs[i].rs0};
            rf_data = {vecs[i].rf1, vecs[i].rf0};
            xw = vecs[i].xw; xr = vecs[i].xr; xd = vecs[i].xd;
            ww = vecs[i].ww; wbrd = vecs[i].wr; wd = vecs[i].wd;
            @(posedge clk); #1;
            chk($sformatf("vec%0d.valid", i), 192'(ov), 192'(vecs[i].ev));
            chk($sformatf("vec%0d.data", i),  192'(od), 192'({vecs[i].ed1, vecs[i].ed0}));
            chk($sformatf("vec%0d.addr", i),  192'(oa), 192'({vecs[i].ea1, vecs[i].ea0}));
            chk($sformatf("vec%0d.sel", i),   192'(os), 192'({vecs[i].es1, vecs[i].es0}));
            @(negedge clk);
        end

        // Asynchronous reset between edges
        idle_inputs();
        vld = 1; rs_addr = {5'd2, 5'd1}; rf_data = {32'h0, 32'hDEADBEEF};
        @(posedge clk); #1;
        chk("prerst.data", 192'(od), 192'({32'h0, 32'hDEADBEEF}));
        chk("prerst.valid", 192'(ov), 192'(1'b1));
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        @(posedge clk); #1;
        chk_all_zero("rsthold");
        @(negedge clk);
        rst_n = 1'b1;

        // Wide build: independent hazard on each lane, then a stall snoop on lane 2
        idle_inputs();
        w_vld = 1; w_rs = {5'd3, 5'd2, 5'd1};
        w_rf = {64'h9999_AAAA_BBBB_CCCC, 64'h0BAD_0BAD_0BAD_0BAD, 64'h0DEF_0DEF_0DEF_0DEF};
        w_xw = 1; w_xr = 5'd1; w_xd = 64'h1111_2222_3333_4444;
        w_ww = 1; w_wr = 5'd2; w_wd = 64'h5555_6666_7777_8888;
        @(posedge clk); #1;
        chk("wide.valid", 192'(w_ov), 192'(1'b1));
        chk("wide.data", w_od, {64'h9999_AAAA_BBBB_CCCC, 64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444});
        chk("wide.addr", 192'(w_oa), 192'({5'd3, 5'd2, 5'd1}));
        chk("wide.sel", 192'(w_os), 192'(6'b00_01_10));
        @(negedge clk);
        w_stall = 1; w_xw = 1; w_xr = 5'd3; w_ww = 1; w_wr = 5'd3; w_wd = 64'hFEDC_BA98_7654_3210;
        w_rs = '0; w_vld = 0;
        @(posedge clk); #1;
        chk("wide.snoop.data", w_od, {64'hFEDC_BA98_7654_3210, 64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444});
        chk("wide.snoop.sel", 192'(w_os), 192'(6'b01_01_10));
        chk("wide.snoop.addr", 192'(w_oa), 192'({5'd3, 5'd2, 5'd1}));
        chk("wide.snoop.valid", 192'(w_ov), 192'(1'b1));
        @(negedge clk);

        // Randomized traffic on the default build against the behavioural model
        idle_inputs();
        flush = 1;
        model_edge();
        @(posedge clk); #1;
        @(negedge clk);
        for (int i = 0; i < 400; i++) begin
            logic [63:0] md;
            logic [9:0]  ma;
            logic [3:0]  ms;
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 11) == 0);
            vld   = 1'($urandom_range(0, 1));
            for (int k = 0; k < 2; k++)
                rs_addr[k*5 +: 5] = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                                                 : 5'($urandom_range(0, 3));
            rf_data = {$urandom, $urandom};
            xw = 1'($urandom_range(0, 1)); xr = 5'($urandom_range(0, 3)); xd = $urandom;
            ww = 1'($urandom_range(0, 1)); wbrd = 5'($urandom_range(0, 3)); wd = $urandom;
            model_edge();
            for (int k = 0; k < 2; k++) begin
                md[k*32 +: 32] = m_data[k];
                ma[k*5 +: 5]   = m_addr[k];
                ms[k*2 +: 2]   = m_sel[k];
            end
            @(posedge clk); #1;
            chk($sformatf("rnd%0d.valid", i), 192'(ov), 192'(m_valid));
            chk($sformatf("rnd%0d.data", i),  192'(od), 192'(md));
            chk($sformatf("rnd%0d.addr", i),  192'(oa), 192'(ma));
            chk($sformatf("rnd%0d.sel", i),   192'(os), 192'(ms));
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
